mcs51_xbus_responder: RTL and testbench
=======================================

// Module: mcs51_xbus_responder
// PURPOSE
//  External-bus slave for the MCS-51 core: the memory-side end of the ALE/PSEN/RD/WR multiplexed P0/P2 bus
//  driven by the control unit. Latches the address, serves code fetches (PSEN) and MOVX reads (RD) by driving
//  P0, captures MOVX writes (WR), and forwards each access to a backing store over a req/ack port.
//  Sits between the core's port pins and the code/xdata memory models in the SoC and testbench.
// PARAMETERS
//  TIMEOUT  16  max cycles mem_req may wait for mem_ack before the access is abandoned (range 2..255)
// PORTS
//  clk          in   1   system clock; all inputs sampled on rising edge
//  reset        in   1   synchronous, active-high reset
//  ale          in   1   address latch enable, active high
//  psen_n       in   1   program store enable, active low
//  rd_n         in   1   xdata read strobe, active low
//  wr_n         in   1   xdata write strobe, active low
//  p0_in        in   8   P0 pins (addr low / write data)
//  p2_in        in   8   P2 pins (addr high)
//  p0_out       out  8   read data driven onto P0
//  p0_oe        out  1   P0 output enable (1 = responder drives P0)
//  mem_req      out  1   backing-store request; held until mem_ack
//  mem_we       out  1   1 = write, 0 = read; stable while mem_req
//  mem_space    out  1   0 = CODE, 1 = XDATA; stable while mem_req
//  mem_addr     out  16  {addr_hi,addr_lo}; stable while mem_req
//  mem_wdata    out  8   write data; stable while mem_req
//  mem_rdata    in   8   read data, valid in the mem_ack cycle
//  mem_ack      in   1   single-cycle acknowledge
//  clr_err      in   1   clears all sticky error flags (takes priority over a same-cycle set)
//  err_late     out  1   sticky: read strobe released before data was available
//  err_overlap  out  1   sticky: more than one strobe low, or ALE high with a strobe low
//  err_timeout  out  1   sticky: mem_ack not received within TIMEOUT cycles
// BEHAVIOUR
//  Reset: all outputs 0, p0_oe 0, addr_hi/addr_lo 0, sync regs to idle (ale 0, strobes 1), state IDLE.
//  Reset mid-access: takes effect the next edge; p0_oe and mem_req drop immediately, no error flag set.
//  Input sampling: every input registered once (s_*); a previous-sample copy gives edges. All decisions use s_*.
//  Address latch: every cycle s_ale=1 -> addr_lo<=s_p0, addr_hi<=s_p2; frozen while s_ale=0. A strobe with no
//   preceding ALE (MOVX cycle with ALE suppressed) uses the last latched address.
//  States: IDLE, RD_WAIT, RD_DRIVE, RD_ABORT, WR_CAPT, WR_WAIT.
//  IDLE: falling edge of s_psen_n -> RD_WAIT with mem_space=0; s_rd_n -> RD_WAIT with mem_space=1;
//   s_wr_n -> WR_CAPT. mem_req rises the cycle after the edge is seen; mem_we=0 for reads.
//  RD_WAIT: on mem_ack -> p0_out<=mem_rdata, p0_oe=1 next cycle, mem_req=0, go RD_DRIVE.
//   Strobe seen high before ack -> RD_ABORT, set err_late.
//  RD_DRIVE: hold p0_out/p0_oe while the strobe stays low; strobe seen high -> p0_oe=0 next cycle, go IDLE.
//   Read latency = edge sample + 1 req cycle + memory latency + 1 cycle.
//  RD_ABORT: keep mem_req until mem_ack (rdata discarded), never drive P0, then IDLE.
//  WR_CAPT: each cycle s_wr_n=0 -> mem_wdata<=s_p0. Rising edge of s_wr_n -> mem_req=1, mem_we=1, mem_space=1
//   next cycle, go WR_WAIT; the data written is the last P0 sample taken while WR was low.
//  WR_WAIT: on mem_ack -> mem_req=0, go IDLE.
//  Timeout: 8-bit counter clears on mem_req rise, counts while mem_req=1. Reaching TIMEOUT with no ack ->
//   mem_req=0, err_timeout=1, go IDLE, no P0 drive. An ack in the same cycle as the limit counts as success.
//  Overlap: two or more strobes low in one sample, or s_ale=1 with any strobe low -> err_overlap=1. If this
//   occurs in IDLE, no access starts. If it occurs mid-access, p0_oe drops next cycle and the FSM continues
//   the memory handshake without driving, then returns to IDLE.
//  New strobe edges are ignored outside IDLE.
//  p0_oe must never be 1 while s_psen_n=s_rd_n=1, apart from the single release cycle.
// TESTING
//  Code fetch: ALE hi with p2=0x12,p0=0x34 then fall, psen_n low, store acks 2 cycles later with 0xA5 ->
//   mem_addr=0x1234, space=0, p0_out=0xA5/p0_oe=1 until psen_n high, then oe=0 next cycle.
//  MOVX write: addr 0x8001, wr_n low 3 cycles with p0=0x5A, rise -> one req we=1 space=1 addr 0x8001 wdata 0x5A.
//  MOVX read, no ALE: rd_n low after the previous access to 0x8001 -> req addr 0x8001 space=1, rdata driven.
//  Late strobe: psen_n pulse of 2 cycles, ack after 6 -> err_late=1, p0_oe never 1, mem_req held until ack.
//  Timeout: TIMEOUT=4, never ack -> mem_req high exactly 4 cycles, err_timeout=1; clr_err clears it.
//  Overlap/reset: rd_n and wr_n low together -> err_overlap=1, no req; reset during RD_DRIVE -> oe=0 next edge.

Source files
------------

// File: rtl/mcs51_xbus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mcs51_xbus_responder
//  Description : Memory-side responder for the MCS-51 multiplexed external
//                bus. Latches the address, answers code fetches and MOVX
//                reads by driving P0, captures MOVX writes, and forwards each
//                access to a backing store over a req/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcs51_xbus_responder #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ale,
  input  logic        psen_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  p0_in,
  input  logic [7:0]  p2_in,
  output logic [7:0]  p0_out,
  output logic        p0_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_space,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        clr_err,
  output logic        err_late,
  output logic        err_overlap,
  output logic        err_timeout
);

  // Last counter value at which a missing ack abandons the access.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_DRIVE = 3'd2,
    ST_RD_ABORT = 3'd3,
    ST_WR_CAPT  = 3'd4,
    ST_WR_WAIT  = 3'd5
  } state_t;

  // Registered pin samples and their previous-cycle copies (strobes only).
  logic       s_ale_q, s_psen_n_q, s_rd_n_q, s_wr_n_q;
  logic       p_psen_n_q, p_rd_n_q, p_wr_n_q;
  logic [7:0] s_p0_q, s_p2_q;

  state_t     state_q, state_d;
  logic [7:0] addr_lo_q, addr_lo_d, addr_hi_q, addr_hi_d;
  logic [7:0] p0_out_q, p0_out_d;
  logic       p0_oe_q, p0_oe_d;
  logic       req_q, req_d;
  logic       we_q, we_d;
  logic       space_q, space_d;
  logic [15:0] maddr_q, maddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_late_q, err_late_d;
  logic       err_ovl_q, err_ovl_d;
  logic       err_tmo_q, err_tmo_d;

  logic w_psen_fall, w_rd_fall, w_wr_fall;
  logic w_overlap, w_strobe_low, w_tmo;
  logic w_set_late, w_set_tmo;
  logic [1:0] w_nlow;

  assign w_psen_fall  = p_psen_n_q & ~s_psen_n_q;
  assign w_rd_fall    = p_rd_n_q   & ~s_rd_n_q;
  assign w_wr_fall    = p_wr_n_q   & ~s_wr_n_q;
  assign w_nlow       = 2'(!s_psen_n_q) + 2'(!s_rd_n_q) + 2'(!s_wr_n_q);
  assign w_overlap    = (w_nlow >= 2'd2) || (s_ale_q && (w_nlow != 2'd0));
  // The strobe that owns the current read: PSEN for CODE, RD for XDATA.
  assign w_strobe_low = space_q ? ~s_rd_n_q : ~s_psen_n_q;
  // Ack arriving in the limit cycle wins, so timeout is only declared without ack.
  assign w_tmo        = req_q && !mem_ack && (cnt_q == c_tmo_last);

  // Input sampling and edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ale_q    <= 1'b0;
      s_psen_n_q <= 1'b1;
      s_rd_n_q   <= 1'b1;
      s_wr_n_q   <= 1'b1;
      p_psen_n_q <= 1'b1;
      p_rd_n_q   <= 1'b1;
      p_wr_n_q   <= 1'b1;
      s_p0_q     <= 8'h00;
      s_p2_q     <= 8'h00;
    end else begin
      s_ale_q    <= ale;
      s_psen_n_q <= psen_n;
      s_rd_n_q   <= rd_n;
      s_wr_n_q   <= wr_n;
      p_psen_n_q <= s_psen_n_q;
      p_rd_n_q   <= s_rd_n_q;
      p_wr_n_q   <= s_wr_n_q;
      s_p0_q     <= p0_in;
      s_p2_q     <= p2_in;
    end
  end

  // Next-state, handshake, address latch and error-flag logic.
  always_comb begin
    state_d    = state_q;
    addr_lo_d  = addr_lo_q;
    addr_hi_d  = addr_hi_q;
    p0_out_d   = p0_out_q;
    p0_oe_d    = p0_oe_q;
    req_d      = req_q;
    we_d       = we_q;
    space_d    = space_q;
    maddr_d    = maddr_q;
    wdata_d    = wdata_q;
    cnt_d      = req_q ? cnt_q + 8'd1 : cnt_q;
    w_set_late = 1'b0;
    w_set_tmo  = 1'b0;

    if (s_ale_q) begin
      addr_lo_d = s_p0_q;
      addr_hi_d = s_p2_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!w_overlap) begin
          if (w_psen_fall || w_rd_fall) begin
            state_d = ST_RD_WAIT;
            req_d   = 1'b1;
            we_d    = 1'b0;
            space_d = ~w_psen_fall;
            maddr_d = {addr_hi_q, addr_lo_q};
            cnt_d   = 8'd0;
          end else if (w_wr_fall) begin
            state_d = ST_WR_CAPT;
            wdata_d = s_p0_q;
          end
        end
      end
      ST_RD_WAIT: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (!w_strobe_low) begin
            // Data arrived too late for a strobe that has already gone.
            w_set_late = 1'b1;
            state_d    = ST_IDLE;
          end else if (w_overlap) begin
            state_d = ST_IDLE;
          end else begin
            p0_out_d = mem_rdata;
            p0_oe_d  = 1'b1;
            state_d  = ST_RD_DRIVE;
          end
        end else if (w_tmo) begin
          req_d      = 1'b0;
          w_set_tmo  = 1'b1;
          w_set_late = ~w_strobe_low;
          state_d    = ST_IDLE;
        end else if (!w_strobe_low) begin
          w_set_late = 1'b1;
          state_d    = ST_RD_ABORT;
        end else if (w_overlap) begin
          state_d = ST_RD_ABORT;
        end
      end
      ST_RD_DRIVE: begin
        if (!w_strobe_low || w_overlap) begin
          p0_oe_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RD_ABORT: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (w_tmo) begin
          req_d     = 1'b0;
          w_set_tmo = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WR_CAPT: begin
        if (!s_wr_n_q) begin
          wdata_d = s_p0_q;
        end else begin
          state_d = ST_WR_WAIT;
          req_d   = 1'b1;
          we_d    = 1'b1;
          space_d = 1'b1;
          maddr_d = {addr_hi_q, addr_lo_q};
          cnt_d   = 8'd0;
        end
      end
      ST_WR_WAIT: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (w_tmo) begin
          req_d     = 1'b0;
          w_set_tmo = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_late_d = clr_err ? 1'b0 : (err_late_q | w_set_late);
    err_ovl_d  = clr_err ? 1'b0 : (err_ovl_q  | w_overlap);
    err_tmo_d  = clr_err ? 1'b0 : (err_tmo_q  | w_set_tmo);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_lo_q  <= 8'h00;
      addr_hi_q  <= 8'h00;
      p0_out_q   <= 8'h00;
      p0_oe_q    <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      space_q    <= 1'b0;
      maddr_q    <= 16'h0000;
      wdata_q    <= 8'h00;
      cnt_q      <= 8'h00;
      err_late_q <= 1'b0;
      err_ovl_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      addr_hi_q  <= addr_hi_d;
      p0_out_q   <= p0_out_d;
      p0_oe_q    <= p0_oe_d;
      req_q      <= req_d;
      we_q       <= we_d;
      space_q    <= space_d;
      maddr_q    <= maddr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_late_q <= err_late_d;
      err_ovl_q  <= err_ovl_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign p0_out      = p0_out_q;
  assign p0_oe       = p0_oe_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_space   = space_q;
  assign mem_addr    = maddr_q;
  assign mem_wdata   = wdata_q;
  assign err_late    = err_late_q;
  assign err_overlap = err_ovl_q;
  assign err_timeout = err_tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_mcs51_xbus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcs51_xbus_responder
//  Description : Directed self-checking bench for mcs51_xbus_responder.
//                A second instance with TIMEOUT=4 and no acknowledge exercises
//                the abandoned-access path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcs51_xbus_responder;

  logic        clk = 1'b0;
  logic        reset, ale, psen_n, rd_n, wr_n, clr_err, mem_ack;
  logic [7:0]  p0_in, p2_in, mem_rdata;
  logic        ack_t4 = 1'b0;

  logic [7:0]  p0_out, t4_p0_out, mem_wdata, t4_wdata;
  logic        p0_oe, mem_req, mem_we, mem_space, err_late, err_overlap, err_timeout;
  logic        t4_oe, t4_req, t4_we, t4_space, t4_late, t4_ovl, t4_tmo;
  logic [15:0] mem_addr, t4_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mcs51_xbus_responder #(.TIMEOUT(16)) u_dut (
    .clk(clk), .reset(reset), .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
    .p0_in(p0_in), .p2_in(p2_in), .p0_out(p0_out), .p0_oe(p0_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_space(mem_space), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .clr_err(clr_err),
    .err_late(err_late), .err_overlap(err_overlap), .err_timeout(err_timeout)
  );

  mcs51_xbus_responder #(.TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .reset(reset), .ale(ale), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n),
    .p0_in(p0_in), .p2_in(p2_in), .p0_out(t4_p0_out), .p0_oe(t4_oe),
    .mem_req(t4_req), .mem_we(t4_we), .mem_space(t4_space), .mem_addr(t4_addr),
    .mem_wdata(t4_wdata), .mem_rdata(mem_rdata), .mem_ack(ack_t4), .clr_err(clr_err),
    .err_late(t4_late), .err_overlap(t4_ovl), .err_timeout(t4_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ale = 1'b0; psen_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    clr_err = 1'b0; mem_ack = 1'b0; p0_in = 8'h00; p2_in = 8'h00; mem_rdata = 8'h00;
    tick(); tick();
    reset = 1'b0;
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_oe", {15'd0, p0_oe}, 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_errs", {13'd0, err_late, err_overlap, err_timeout}, 16'd0);
    tick();

    // Code fetch at 0x1234, store acks two cycles after request.
    ale = 1'b1; p2_in = 8'h12; p0_in = 8'h34;
    tick();
    ale = 1'b0; psen_n = 1'b0; p0_in = 8'hFF;
    tick();
    tick();
    chk("cf_req", {15'd0, mem_req}, 16'd1);
    chk("cf_addr", mem_addr, 16'h1234);
    chk("cf_space_we", {14'd0, mem_space, mem_we}, 16'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    chk("cf_oe", {15'd0, p0_oe}, 16'd1);
    chk("cf_data", {8'd0, p0_out}, 16'h00A5);
    chk("cf_req_drop", {15'd0, mem_req}, 16'd0);
    tick();
    chk("cf_hold", {7'd0, p0_oe, p0_out}, 16'h01A5);
    psen_n = 1'b1;
    tick();
    chk("cf_release_cycle", {15'd0, p0_oe}, 16'd1);
    tick();
    chk("cf_oe_off", {15'd0, p0_oe}, 16'd0);
    tick();

    // MOVX write 0x5A to 0x8001; bus changes after WR rises must not be captured.
    ale = 1'b1; p2_in = 8'h80; p0_in = 8'h01;
    tick();
    ale = 1'b0; p0_in = 8'h5A; wr_n = 1'b0;
    tick(); tick(); tick();
    chk("wr_no_req_yet", {15'd0, mem_req}, 16'd0);
    wr_n = 1'b1; p0_in = 8'hEE;
    tick();
    chk("wr_no_req_rise", {15'd0, mem_req}, 16'd0);
    tick();
    chk("wr_req", {13'd0, mem_req, mem_we, mem_space}, 16'd7);
    chk("wr_addr", mem_addr, 16'h8001);
    chk("wr_data", {8'd0, mem_wdata}, 16'h005A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("wr_req_drop", {15'd0, mem_req}, 16'd0);
    tick();
    chk("wr_single_req", {15'd0, mem_req}, 16'd0);

    // MOVX read with ALE suppressed reuses 0x8001.
    rd_n = 1'b0;
    tick(); tick();
    chk("rd_req", {13'd0, mem_req, mem_we, mem_space}, 16'd5);
    chk("rd_addr", mem_addr, 16'h8001);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    chk("rd_drive", {7'd0, p0_oe, p0_out}, 16'h013C);
    rd_n = 1'b1;
    tick(); tick();
    chk("rd_oe_off", {15'd0, p0_oe}, 16'd0);

    // Late strobe: 2-cycle PSEN pulse, ack arrives six cycles after it began.
    psen_n = 1'b0;
    tick(); tick();
    chk("late_req", {15'd0, mem_req}, 16'd1);
    psen_n = 1'b1;
    tick(); tick();
    chk("late_flag", {15'd0, err_late}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      chk("late_hold_req_no_oe", {14'd0, mem_req, p0_oe}, 16'd2);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    chk("late_done", {7'd0, mem_req, p0_oe, p0_out}, 16'h003C);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("late_clr", {13'd0, err_late, err_overlap, err_timeout}, 16'd0);
    chk("t4_clr", {15'd0, t4_tmo}, 16'd0);
    tick(); tick();

    // Timeout on the TIMEOUT=4 instance; main instance acks normally.
    rd_n = 1'b0;
    tick(); tick();
    chk("tmo_req_c1", {15'd0, t4_req}, 16'd1);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0;
    chk("tmo_req_c2", {15'd0, t4_req}, 16'd1);
    tick();
    chk("tmo_req_c3", {15'd0, t4_req}, 16'd1);
    tick();
    chk("tmo_req_c4", {15'd0, t4_req}, 16'd1);
    tick();
    chk("tmo_req_off", {15'd0, t4_req}, 16'd0);
    chk("tmo_flag", {15'd0, t4_tmo}, 16'd1);
    chk("tmo_no_oe", {15'd0, t4_oe}, 16'd0);
    chk("tmo_main_ok", {14'd0, err_timeout, p0_oe}, 16'd1);
    rd_n = 1'b1;
    tick(); tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo_clr", {15'd0, t4_tmo}, 16'd0);

    // Overlap: RD and WR low together, no access may start.
    rd_n = 1'b0; wr_n = 1'b0;
    tick(); tick();
    chk("ovl_flag", {15'd0, err_overlap}, 16'd1);
    chk("ovl_no_req", {15'd0, mem_req}, 16'd0);
    tick();
    chk("ovl_still_no_req", {15'd0, mem_req}, 16'd0);
    rd_n = 1'b1; wr_n = 1'b1;
    tick(); tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovl_clr", {15'd0, err_overlap}, 16'd0);

    // Reset while driving P0.
    psen_n = 1'b0;
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    chk("rstmid_drive", {7'd0, p0_oe, p0_out}, 16'h0199);
    reset = 1'b1;
    tick();
    reset = 1'b0; psen_n = 1'b1;
    chk("rstmid_oe", {14'd0, p0_oe, mem_req}, 16'd0);
    chk("rstmid_pout", {8'd0, p0_out}, 16'd0);
    tick(); tick(); tick();
    chk("rstmid_quiet", {11'd0, mem_req, p0_oe, err_late, err_overlap, err_timeout}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
